// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS symbol constants, mode encoding and disparity width
package tmds_pkg;

   localparam int DISP_W = 5;

   typedef enum logic [1:0] {
      MODE_CTL    = 2'd0,
      MODE_VIDEO  = 2'd1,
      MODE_VGB    = 2'd2,
      MODE_ISLAND = 2'd3
   } mode_t;

   localparam logic [9:0] CTL_SYM [0:3] = '{
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011
   };

   localparam logic [9:0] VGB_SYM_CH02 = 10'b1011001100;
   localparam logic [9:0] VGB_SYM_CH1  = 10'b0100110011;

   localparam logic [9:0] TERC4_SYM [0:15] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

endpackage

// File: rtl/tmds_qm_encoder.sv
// rtl/tmds_qm_encoder.sv - combinational transition-minimisation stage (d -> q_m, ones count)
module tmds_qm_encoder
   import tmds_pkg::*;
(
   input  logic [7:0] d,
   output logic [8:0] q_m,
   output logic [3:0] n1q
);

   logic [3:0] n1d;
   logic       use_xnor;

   always_comb begin
      n1d = '0;
      for (int i = 0; i < 8; i++) begin
         n1d = n1d + {3'b000, d[i]};
      end
      // XNOR chain when the byte is ones-heavy; ties broken on d[0]
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

      q_m    = '0;
      q_m[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
      end
      q_m[8] = ~use_xnor;

      n1q = '0;
      for (int i = 0; i < 8; i++) begin
         n1q = n1q + {3'b000, q_m[i]};
      end
   end

endmodule

// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - two-stage per-channel TMDS encoder with running disparity
// Optional TERC4 data-island symbols are built when TMDS_TERC4_EN is defined.
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL = 0
) (
   input  logic              pixel_clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic [1:0]        ctl,
   input  logic [7:0]        pixel_data,
`ifdef TMDS_TERC4_EN
   input  logic [3:0]        terc4_data,
`endif
   output logic [9:0]        tmds,
   output logic [DISP_W-1:0] disparity
);

   localparam logic [9:0] VGB_SYM = (CHANNEL == 1) ? VGB_SYM_CH1 : VGB_SYM_CH02;

   logic [8:0] qm_c;
   logic [3:0] n1q_c;

   mode_t      s1_mode;
   logic [1:0] s1_ctl;
   logic [8:0] s1_qm;
   logic [3:0] s1_n1q;
`ifdef TMDS_TERC4_EN
   logic [3:0] s1_terc4;
`endif

   logic signed [DISP_W-1:0] cnt;
   logic signed [DISP_W-1:0] nxt_cnt;
   logic signed [DISP_W-1:0] d10;
   logic [3:0]               n0q;
   logic                     qm8;
   logic [9:0]               nxt_sym;

   tmds_qm_encoder u_qm (
      .d   (pixel_data),
      .q_m (qm_c),
      .n1q (n1q_c)
   );

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         s1_mode <= MODE_CTL;
         s1_ctl  <= 2'b00;
         s1_qm   <= '0;
         s1_n1q  <= '0;
`ifdef TMDS_TERC4_EN
         s1_terc4 <= '0;
`endif
      end else begin
`ifdef TMDS_TERC4_EN
         s1_mode  <= mode_t'(mode);
         s1_terc4 <= terc4_data;
`else
         s1_mode  <= (mode_t'(mode) == MODE_ISLAND) ? MODE_CTL : mode_t'(mode);
`endif
         s1_ctl  <= ctl;
         s1_qm   <= qm_c;
         s1_n1q  <= n1q_c;
      end
   end

   always_comb begin
      n0q     = 4'd8 - s1_n1q;
      d10     = $signed({1'b0, s1_n1q}) - $signed({1'b0, n0q});
      qm8     = s1_qm[8];
      nxt_sym = CTL_SYM[s1_ctl];
      nxt_cnt = '0;
      case (s1_mode)
         MODE_VIDEO: begin
            if ((cnt == '0) || (d10 == '0)) begin
               nxt_sym = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
               nxt_cnt = qm8 ? (cnt + d10) : (cnt - d10);
            end else if (((cnt > 5'sd0) && (d10 > 5'sd0)) || ((cnt < 5'sd0) && (d10 < 5'sd0))) begin
               nxt_sym = {1'b1, qm8, ~s1_qm[7:0]};
               nxt_cnt = cnt + (qm8 ? 5'sd2 : 5'sd0) - d10;
            end else begin
               nxt_sym = {1'b0, qm8, s1_qm[7:0]};
               nxt_cnt = cnt + d10 - (qm8 ? 5'sd0 : 5'sd2);
            end
         end
         MODE_VGB: nxt_sym = VGB_SYM;
`ifdef TMDS_TERC4_EN
         MODE_ISLAND: nxt_sym = TERC4_SYM[s1_terc4];
`endif
         default: ;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         tmds <= CTL_SYM[0];
         cnt  <= '0;
      end else begin
         tmds <= nxt_sym;
         cnt  <= nxt_cnt;
      end
   end

   assign disparity = cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - directed and reference-model checks of tmds_channel_encoder
module tb_tmds_channel_encoder;

   logic       pixel_clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [1:0] ctl = 2'd0;
   logic [7:0] pixel_data = 8'd0;
   logic [3:0] terc4_data = 4'd0;
   logic [9:0] tmds0, tmds1;
   logic [4:0] disp0, disp1;

   int n_checks = 0;
   int n_fail = 0;
   int m_cnt = 0;

   // two-deep expectation pipe matching the encoder latency
   logic       p_v [0:1];
   logic [9:0] p_s [0:1];
   logic [9:0] p_s1 [0:1];
   logic [4:0] p_d [0:1];
   string      p_tag [0:1];

   localparam logic [9:0] C00 = 10'b1101010100;

   always #5 pixel_clk = ~pixel_clk;

   tmds_channel_encoder #(.CHANNEL(0)) dut0 (
      .pixel_clk  (pixel_clk),
      .rst        (rst),
      .mode       (mode),
      .ctl        (ctl),
      .pixel_data (pixel_data),
`ifdef TMDS_TERC4_EN
      .terc4_data (terc4_data),
`endif
      .tmds       (tmds0),
      .disparity  (disp0)
   );

   tmds_channel_encoder #(.CHANNEL(1)) dut1 (
      .pixel_clk  (pixel_clk),
      .rst        (rst),
      .mode       (mode),
      .ctl        (ctl),
      .pixel_data (pixel_data),
`ifdef TMDS_TERC4_EN
      .terc4_data (terc4_data),
`endif
      .tmds       (tmds1),
      .disparity  (disp1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // es/ed: symbol and disparity expected two steps later for this entry
   task automatic step(input logic r, input logic [1:0] m, input logic [1:0] c,
                       input logic [7:0] d, input logic [3:0] nib, input logic chk,
                       input logic [9:0] es, input logic [4:0] ed, input string tag);
      @(negedge pixel_clk);
      if (p_v[1]) begin
         check($sformatf("%s tmds ch0", p_tag[1]), {22'd0, tmds0}, {22'd0, p_s[1]});
         check($sformatf("%s disparity", p_tag[1]), {27'd0, disp0}, {27'd0, p_d[1]});
         check($sformatf("%s tmds ch1", p_tag[1]), {22'd0, tmds1}, {22'd0, p_s1[1]});
      end
      p_v[1] = p_v[0]; p_s[1] = p_s[0]; p_s1[1] = p_s1[0]; p_d[1] = p_d[0]; p_tag[1] = p_tag[0];
      p_v[0] = chk; p_s[0] = es; p_d[0] = ed; p_tag[0] = tag;
      p_s1[0] = (m == 2'd2 && es == 10'b1011001100) ? 10'b0100110011 : es;
      rst = r; mode = m; ctl = c; pixel_data = d; terc4_data = nib;
   endtask

   task automatic ref_video(input logic [7:0] d, output logic [9:0] sym);
      int ones, n1, n0;
      logic xn, q8;
      logic [7:0] q;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += d[i];
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] == d[i]) : (q[i-1] != d[i]);
      q8 = !xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += q[i];
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
         sym = {!q8, q8, q8 ? q : ~q};
         m_cnt += q8 ? (n1 - n0) : (n0 - n1);
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
         sym = {1'b1, q8, ~q};
         m_cnt += (q8 ? 2 : 0) + n0 - n1;
      end else begin
         sym = {1'b0, q8, q};
         m_cnt += n1 - n0 - (q8 ? 0 : 2);
      end
   endtask

   initial begin
      logic [9:0] es;
      logic [7:0] d;
      int cnt_now;
      p_v[0] = 1'b0; p_v[1] = 1'b0;
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              4'($urandom_range(0, 15)), 1'b1, C00, 5'd0, "reset");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "post_reset");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "post_reset");
      step(1'b0, 2'd0, 2'b01, 8'h00, 4'h0, 1'b1, 10'b0010101011, 5'd0, "ctl01");
      step(1'b0, 2'd0, 2'b11, 8'h00, 4'h0, 1'b1, 10'b1010101011, 5'd0, "ctl11");
      step(1'b0, 2'd0, 2'b10, 8'h00, 4'h0, 1'b1, 10'b0101010100, 5'd0, "ctl10");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b0100000000, 5'b11000, "vid00_a");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b1111111111, 5'b00010, "vid00_b");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b0100000000, 5'b11010, "vid00_c");
      step(1'b0, 2'd2, 2'b00, 8'h00, 4'h0, 1'b1, 10'b1011001100, 5'd0, "guard");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b0100000000, 5'b11000, "vid_after_gb");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "ctl_mid");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b0100000000, 5'b11000, "vid_after_ctl");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "ctl_pre_ff");
      step(1'b0, 2'd1, 2'b00, 8'hFF, 4'h0, 1'b1, 10'b1000000000, 5'b11000, "vidff_a");
      step(1'b0, 2'd1, 2'b00, 8'hFF, 4'h0, 1'b1, 10'b0011111111, 5'b11110, "vidff_b");
`ifdef TMDS_TERC4_EN
      step(1'b0, 2'd3, 2'b10, 8'h00, 4'h5, 1'b1, 10'b0100011110, 5'd0, "island");
`else
      step(1'b0, 2'd3, 2'b10, 8'h00, 4'h5, 1'b1, 10'b0101010100, 5'd0, "island");
`endif
      // reset mid-stream drops the symbol in flight and the one being captured
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "abort_a");
      step(1'b1, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "abort_b");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b0100000000, 5'b11000, "after_abort_a");
      step(1'b0, 2'd1, 2'b00, 8'h00, 4'h0, 1'b1, 10'b1111111111, 5'b00010, "after_abort_b");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b1, C00, 5'd0, "ctl_pre_rand");
      m_cnt = 0;
      for (int i = 0; i < 10000; i++) begin
         d = 8'($urandom_range(0, 255));
         ref_video(d, es);
         cnt_now = m_cnt;
         step(1'b0, 2'd1, 2'b00, d, 4'h0, 1'b1, es, 5'(cnt_now), "rand_video");
      end
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b0, C00, 5'd0, "flush");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b0, C00, 5'd0, "flush");
      step(1'b0, 2'd0, 2'b00, 8'h00, 4'h0, 1'b0, C00, 5'd0, "flush");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
